// File: rtl/axi_gpio_lite_master.sv
// rtl/axi_gpio_lite_master.sv - single-outstanding AXI4-Lite master for the GPIO register port
module axi_gpio_lite_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic                  timeout_err,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int          STRB_W    = DATA_W / 8;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e              state_q;
  logic                cmd_ready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic                rsp_write_q;
  logic [15:0]         wait_cnt_q;
  logic [15:0]         wait_cnt_d;
  logic                wait_hit_d;
  logic                timeout_err_q;
  logic                aw_done;
  logic                w_done;

  // Next wait-count value if the FSM stays put, saturating so it never wraps back under TIMEOUT
  always_comb begin
    wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    wait_hit_d = (wait_cnt_d == TIMEOUT_C);
    // a channel counts as done once its valid is gone or is being accepted this cycle
    aw_done    = !awvalid_q || m_axi_awready;
    w_done     = !wvalid_q  || m_axi_wready;
  end

  // Transaction FSM; every AXI and response output is a register so no valid follows a ready combinationally
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_write_q   <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q   <= 1'b0;
            addr_q        <= cmd_addr;
            wdata_q       <= cmd_wdata;
            wstrb_q       <= cmd_wstrb;
            rsp_write_q   <= cmd_write;
            timeout_err_q <= 1'b0;
            if (cmd_write) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_REQ;
              arvalid_q <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        WR_REQ: begin
          // AW and W retire independently; the state moves on once neither is outstanding
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q    <= WR_RESP;
            bready_q   <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_hit_d) timeout_err_q <= 1'b1;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            state_q     <= RSP;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= m_axi_bresp;
            rsp_rdata_q <= '0;
            wait_cnt_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_hit_d) timeout_err_q <= 1'b1;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            state_q    <= RD_RESP;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_hit_d) timeout_err_q <= 1'b1;
          end
        end

        RD_RESP: begin
          if (m_axi_rvalid) begin
            state_q     <= RSP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= m_axi_rresp;
            rsp_rdata_q <= m_axi_rdata;
            wait_cnt_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_hit_d) timeout_err_q <= 1'b1;
          end
        end

        RSP: begin
          // waiting on the consumer is not an AXI handshake, so the wait counter stays cleared
          wait_cnt_q <= '0;
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          wait_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_write     = rsp_write_q;
  assign timeout_err   = timeout_err_q;

  // both address channels carry the one latched command address
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_gpio_lite_master.sv
// tb/tb_axi_gpio_lite_master.sv - scoreboard bench for axi_gpio_lite_master against a register-file slave
module tb_axi_gpio_lite_master;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, timeout_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axi_gpio_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout_err(timeout_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard entries are {rsp_write, rsp_rdata, rsp_resp}
  logic [34:0] sb_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] slv_mem[64];

  // slave knobs
  int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit   b_never = 0, r_never = 0, rand_mode = 0;
  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit   aw_done, w_done, ar_done, b_fire, r_fire;
  logic [8:0]  aw_addr_s, ar_addr_s;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;
  int   aw_hi = 0, w_hi = 0;
  bit   p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bready;
  logic [8:0]  p_awaddr, p_araddr;
  logic [35:0] p_w;

  // monitor state
  int   rsp_stall = 0, stall_cnt = 0, n_rsp = 0, rsp_first_cyc = 0, acc_cyc = 0;
  bit   rsp_seen = 0;
  logic [34:0] rsp_first;

  // AXI slave: register file below 0x100, SLVERR above; also checks valid/payload hold rules
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_fire = 0; r_fire = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_bready = 0;
      end else begin
        if (p_awv && !p_awr) begin
          check("aw_valid_hold", m_axi_awvalid, 1);
          check("aw_addr_stable", m_axi_awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          check("w_valid_hold", m_axi_wvalid, 1);
          check("w_data_stable", {m_axi_wstrb, m_axi_wdata}, p_w);
        end
        if (p_arv && !p_arr) begin
          check("ar_valid_hold", m_axi_arvalid, 1);
          check("ar_addr_stable", m_axi_araddr, p_araddr);
        end
        if (m_axi_bready && !p_bready) check("bready_after_aw_w", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
        if (m_axi_awvalid) aw_hi++;
        if (m_axi_wvalid) w_hi++;
        if (b_fire) m_axi_bvalid = 0;
        if (r_fire) m_axi_rvalid = 0;
        if (aw_done && w_done && !m_axi_bvalid && !b_never) begin
          if (b_cnt >= b_dly) begin
            m_axi_bvalid = 1;
            m_axi_bresp  = aw_addr_s[8] ? 2'b10 : 2'b00;
          end else b_cnt++;
        end
        if (ar_done && !m_axi_rvalid && !r_never) begin
          if (r_cnt >= r_dly) begin
            m_axi_rvalid = 1;
            m_axi_rresp  = ar_addr_s[8] ? 2'b10 : 2'b00;
            m_axi_rdata  = ar_addr_s[8] ? 32'h0 : slv_mem[ar_addr_s[7:2]];
          end else r_cnt++;
        end
        m_axi_awready = 0;
        if (m_axi_awvalid && !aw_done) begin
          if (aw_cnt >= aw_dly) m_axi_awready = 1; else aw_cnt++;
        end
        m_axi_wready = 0;
        if (m_axi_wvalid && !w_done) begin
          if (w_cnt >= w_dly) m_axi_wready = 1; else w_cnt++;
        end
        m_axi_arready = 0;
        if (m_axi_arvalid && !ar_done) begin
          if (ar_cnt >= ar_dly) m_axi_arready = 1; else ar_cnt++;
        end
        if (m_axi_awvalid && m_axi_awready) begin aw_done = 1; aw_addr_s = m_axi_awaddr; end
        if (m_axi_wvalid && m_axi_wready) begin w_done = 1; w_data_s = m_axi_wdata; w_strb_s = m_axi_wstrb; end
        if (m_axi_arvalid && m_axi_arready) begin ar_done = 1; ar_addr_s = m_axi_araddr; end
        b_fire = m_axi_bvalid && m_axi_bready;
        if (b_fire) begin
          if (!aw_addr_s[8])
            for (int i = 0; i < 4; i++)
              if (w_strb_s[i]) slv_mem[aw_addr_s[7:2]][8*i +: 8] = w_data_s[8*i +: 8];
          aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
          if (rand_mode) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4);
          end
        end
        r_fire = m_axi_rvalid && m_axi_rready;
        if (r_fire) begin
          ar_done = 0; ar_cnt = 0; r_cnt = 0;
          if (rand_mode) begin ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4); end
        end
        p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
        p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_w = {m_axi_wstrb, m_axi_wdata};
        p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
        p_bready = m_axi_bready;
      end
    end
  end

  // response monitor: optional stall, stability during stall, then pop and compare
  initial begin
    logic [34:0] cur, exp;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_ready = 0; rsp_seen = 0; stall_cnt = 0;
      end else if (rsp_valid) begin
        cur = {rsp_write, rsp_rdata, rsp_resp};
        if (!rsp_seen) begin rsp_seen = 1; rsp_first = cur; rsp_first_cyc = cyc; end
        if (stall_cnt < rsp_stall) begin
          rsp_ready = 0;
          stall_cnt++;
          check("cmd_ready_in_rsp", cmd_ready, 0);
        end else begin
          rsp_ready = 1;
          if (stall_cnt != 0) check("rsp_stable", cur, rsp_first);
          check("sb_nonempty", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check("rsp", cur, exp);
          end
          n_rsp++; stall_cnt = 0; rsp_seen = 0;
          if (rand_mode) rsp_stall = $urandom_range(0, 2);
        end
      end else rsp_ready = 0;
    end
  end

  // issue one command (called at a negedge) and push its expected response
  task automatic send(input logic w, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    logic [1:0]  er;
    logic [31:0] ed;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    acc_cyc = cyc;
    er = a[8] ? 2'b10 : 2'b00;
    if (w) begin
      if (!a[8])
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
      ed = 32'h0;
    end else ed = a[8] ? 32'h0 : ref_mem[a[7:2]];
    sb_q.push_back({w, ed, er});
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (n_rsp < target && t < 400) begin @(negedge clk); t++; end
    if (n_rsp < target) check("rsp_wait_timeout", n_rsp, target);
  endtask

  task automatic wait_sig(input string tag, input int which);
    int t = 0;
    while (!(which == 0 ? m_axi_bready : m_axi_rready) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check(tag, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    for (int i = 0; i < 64; i++) begin ref_mem[i] = 32'h0; slv_mem[i] = 32'h0; end
    ref_mem[2] = 32'hDEAD_BEEF; slv_mem[2] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1;
    #1 check("cmd_ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_after_edge", cmd_ready, 1);

    // zero-wait write
    aw_hi = 0; w_hi = 0;
    send(1, 9'h000, 32'hA5A5_5A5A, 4'hF);
    wait_rsp(1);
    check("wr_latency", rsp_first_cyc - acc_cyc, 3);
    check("wr0_aw_cycles", aw_hi, 1);
    check("wr0_w_cycles", w_hi, 1);

    // awready late by 3, wready late by 1
    aw_dly = 3; w_dly = 1; aw_hi = 0; w_hi = 0;
    send(1, 9'h004, 32'h1234_5678, 4'h3);
    wait_rsp(2);
    check("wr1_aw_cycles", aw_hi, 4);
    check("wr1_w_cycles", w_hi, 2);
    aw_dly = 0; w_dly = 0;

    // slow read with consumer stall
    r_dly = 5; rsp_stall = 4;
    send(0, 9'h008, 32'h0, 4'h0);
    wait_rsp(3);
    r_dly = 0; rsp_stall = 0;

    // write response withheld past TIMEOUT, then SLVERR
    b_never = 1;
    send(1, 9'h104, 32'hFFFF_FFFF, 4'hF);
    wait_sig("bready_wait_timeout", 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("timeout_not_yet", timeout_err, 0);
    @(negedge clk);
    check("timeout_set", timeout_err, 1);
    check("no_reassert_aw_w", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    repeat (3) @(negedge clk);
    b_never = 0;
    wait_rsp(4);
    check("timeout_sticky", timeout_err, 1);
    send(0, 9'h000, 32'h0, 4'h0);
    check("timeout_cleared", timeout_err, 0);
    wait_rsp(5);

    // reset while waiting for read data
    r_never = 1;
    send(0, 9'h010, 32'h0, 4'h0);
    wait_sig("rready_wait_timeout", 1);
    #2 rst_n = 0;
    sb_q.delete();
    #1;
    check("mid_rst_arvalid", m_axi_arvalid, 0);
    check("mid_rst_rready", m_axi_rready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    r_never = 0;
    rst_n = 1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    send(1, 9'h00C, 32'hCAFE_F00D, 4'hF);
    wait_rsp(6);

    // random back-to-back traffic with random stalls
    rand_mode = 1;
    for (int k = 0; k < 100; k++) begin
      logic [8:0] ra;
      ra = 9'($urandom_range(0, 511)) & 9'h1FC;
      send(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_rsp(106);
    check("sb_drained", sb_q.size(), 0);
    check("rsp_count", n_rsp, 106);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
